// File: rtl/wt_cache_pkg.sv
// Shared types for the write-through cache subsystem: fence sequencer state and fence-type encoding.
package wt_cache_pkg;

  typedef enum logic [2:0] {
    FENCE_IDLE     = 3'd0,
    FENCE_DC_FLUSH = 3'd1,
    FENCE_DRAIN_WB = 3'd2,
    FENCE_IC_FLUSH = 3'd3,
    FENCE_IC_WAIT  = 3'd4,
    FENCE_DONE     = 3'd5
  } fence_state_e;

  localparam logic FENCE_DATA  = 1'b0;
  localparam logic FENCE_INSTR = 1'b1;

  // States that wait on an external condition and therefore run the timeout counter.
  function automatic logic fence_is_wait(input fence_state_e s);
    return (s == FENCE_DC_FLUSH) || (s == FENCE_DRAIN_WB) || (s == FENCE_IC_WAIT);
  endfunction

endpackage

// File: rtl/wt_cache_fence_ctrl.sv
// FENCE / FENCE.I sequencer: D$ flush handshake, writebuffer drain, I$ flush and idle wait,
// with a completion pulse and a sticky debug timeout.
module wt_cache_fence_ctrl
  import wt_cache_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 4096,
  localparam int unsigned CntWidth     = $clog2(TimeoutCycles) + 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic fence_req_i,
  input  logic fence_type_i,
  output logic fence_ready_o,
  output logic fence_done_o,
  output logic fence_timeout_o,
  output logic dcache_flush_o,
  input  logic dcache_flush_ack_i,
  input  logic wbuffer_empty_i,
  output logic icache_flush_o,
  input  logic icache_busy_i,
  output logic busy_o
);

  fence_state_e        state_q, state_d;
  logic                type_q;
  logic                abort_q;
  logic                timeout_q;
  logic [CntWidth-1:0] cnt_q;
  logic                accept;
  logic                waiting;
  logic                stay;

  assign accept  = fence_req_i && fence_ready_o;
  assign waiting = fence_is_wait(state_q);
  assign stay    = (state_d == state_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FENCE_IDLE:
        if (accept) state_d = (fence_type_i == FENCE_INSTR) ? FENCE_DC_FLUSH : FENCE_DRAIN_WB;
      // The flush request stays up through an abort; only the ack may end this state.
      FENCE_DC_FLUSH:
        if (dcache_flush_ack_i) state_d = (abort_q || clr_i) ? FENCE_IDLE : FENCE_DRAIN_WB;
      FENCE_DRAIN_WB:
        if (clr_i)                state_d = FENCE_IDLE;
        else if (wbuffer_empty_i) state_d = (type_q == FENCE_INSTR) ? FENCE_IC_FLUSH : FENCE_DONE;
      FENCE_IC_FLUSH:
        state_d = clr_i ? FENCE_IDLE : FENCE_IC_WAIT;
      FENCE_IC_WAIT:
        if (clr_i)               state_d = FENCE_IDLE;
        else if (!icache_busy_i) state_d = FENCE_DONE;
      FENCE_DONE:
        state_d = FENCE_IDLE;
      default:
        state_d = FENCE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FENCE_IDLE;
      type_q    <= FENCE_DATA;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) type_q <= fence_type_i;

      if (state_d == FENCE_IDLE)                   abort_q <= 1'b0;
      else if (state_q == FENCE_DC_FLUSH && clr_i) abort_q <= 1'b1;

      if (!stay)                      cnt_q <= '0;
      else if (waiting && cnt_q != '1) cnt_q <= cnt_q + 1'b1;

      // Flag rises on the edge where the counter lands on TimeoutCycles-1; the wait goes on.
      if (clr_i)
        timeout_q <= 1'b0;
      else if (waiting && stay && cnt_q == CntWidth'(TimeoutCycles - 2))
        timeout_q <= 1'b1;
    end
  end

  assign fence_ready_o   = (state_q == FENCE_IDLE) && !clr_i;
  assign fence_done_o    = (state_q == FENCE_DONE) && !clr_i;
  assign fence_timeout_o = timeout_q;
  assign dcache_flush_o  = (state_q == FENCE_DC_FLUSH);
  assign icache_flush_o  = (state_q == FENCE_IC_FLUSH);
  assign busy_o          = (state_q != FENCE_IDLE);

endmodule

// File: tb/tb_wt_cache_fence_ctrl.sv
// Directed bench for wt_cache_fence_ctrl with TimeoutCycles = 16.
module tb_wt_cache_fence_ctrl;

  logic clk = 1'b0;
  logic rst_ni, clr, req, ftype, ack, empty, ibusy;
  logic ready, done, tmo, dflush, iflush, busy;
  int   errors = 0;
  int   checks = 0;

  wt_cache_fence_ctrl #(.TimeoutCycles(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr),
    .fence_req_i(req), .fence_type_i(ftype),
    .fence_ready_o(ready), .fence_done_o(done), .fence_timeout_o(tmo),
    .dcache_flush_o(dflush), .dcache_flush_ack_i(ack),
    .wbuffer_empty_i(empty),
    .icache_flush_o(iflush), .icache_busy_i(ibusy),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then set and outputs sampled at +1.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int dfl, ifl, dn, ifl_cyc, dn_cyc, tmo15, tmo16, acc, viol;
    rst_ni = 1'b0; clr = 0; req = 0; ftype = 0; ack = 0; empty = 0; ibusy = 0;
    #12;
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_dflush", dflush, 1'b0);
    chk1("rst_tmo", tmo, 1'b0);
    @(negedge clk); rst_ni = 1'b1;
    nxt();

    // 1: FENCE with writebuffer already empty
    req = 1; ftype = 0; empty = 1; #1;
    chk1("t1_ready_c0", ready, 1'b1);
    nxt(); req = 0; #1;
    chk1("t1_busy_c1", busy, 1'b1);
    chk1("t1_done_c1", done, 1'b0);
    chk1("t1_dflush_c1", dflush, 1'b0);
    nxt(); #1;
    chk1("t1_done_c2", done, 1'b1);
    chk1("t1_busy_c2", busy, 1'b1);
    chk1("t1_iflush_c2", iflush, 1'b0);
    nxt(); #1;
    chk1("t1_busy_c3", busy, 1'b0);
    chk1("t1_ready_c3", ready, 1'b1);

    // 2: FENCE.I, late ack, late empty, I$ busy for 4 cycles
    empty = 0; req = 1; ftype = 1; #1;
    nxt(); req = 0;
    dfl = 0; ifl = 0; dn = 0; ifl_cyc = -1; dn_cyc = -1;
    for (int c = 1; c <= 16; c++) begin
      ack = (c == 4); empty = (c >= 7); ibusy = (c >= 9 && c <= 12); #1;
      dfl += int'(dflush); ifl += int'(iflush); dn += int'(done);
      if (iflush) ifl_cyc = c;
      if (done)   dn_cyc = c;
      nxt();
    end
    ack = 0; ibusy = 0;
    chkn("t2_dflush_cycles", dfl, 4);
    chkn("t2_iflush_count", ifl, 1);
    chkn("t2_iflush_cycle", ifl_cyc, 8);
    chkn("t2_done_count", dn, 1);
    chkn("t2_done_cycle", dn_cyc, 14);

    // 3: FENCE stuck on writebuffer -> sticky timeout, then clear
    empty = 0; req = 1; ftype = 0; #1;
    nxt(); req = 0;
    dn_cyc = -1; tmo15 = -1; tmo16 = -1;
    for (int c = 1; c <= 23; c++) begin
      empty = (c >= 21); #1;
      if (c == 15) tmo15 = int'(tmo);
      if (c == 16) tmo16 = int'(tmo);
      if (done && dn_cyc < 0) dn_cyc = c;
      nxt();
    end
    chkn("t3_tmo_c15", tmo15, 0);
    chkn("t3_tmo_c16", tmo16, 1);
    chkn("t3_done_cycle", dn_cyc, 22);
    chk1("t3_tmo_sticky", tmo, 1'b1);
    clr = 1; req = 1; #1;
    chk1("t3_clr_blocks_ready", ready, 1'b0);
    nxt(); clr = 0; req = 0; #1;
    chk1("t3_tmo_cleared", tmo, 1'b0);
    chk1("t3_idle_after_clr", busy, 1'b0);

    // 4: abort during DC_FLUSH
    empty = 1; ibusy = 0; req = 1; ftype = 1; #1;
    nxt(); req = 0;
    dfl = 0; ifl = 0; dn = 0;
    for (int c = 1; c <= 8; c++) begin
      clr = (c == 3); ack = (c == 6); #1;
      dfl += int'(dflush); ifl += int'(iflush); dn += int'(done);
      if (c == 7) begin
        chk1("t4_idle_c7", busy, 1'b0);
        chk1("t4_ready_c7", ready, 1'b1);
      end
      nxt();
    end
    clr = 0; ack = 0;
    chkn("t4_dflush_cycles", dfl, 6);
    chkn("t4_iflush_count", ifl, 0);
    chkn("t4_done_count", dn, 0);

    // 5: request held high, back-to-back FENCE
    empty = 1; req = 1; ftype = 0;
    dn = 0; acc = 0; viol = 0; dn_cyc = 0;
    for (int c = 0; c <= 11; c++) begin
      #1;
      if (ready && req) acc++;
      if (ready && busy) viol++;
      if (done) begin dn++; dn_cyc += c; end
      nxt();
    end
    req = 0;
    chkn("t5_accepts", acc, 4);
    chkn("t5_done_count", dn, 4);
    chkn("t5_done_cycle_sum", dn_cyc, 2 + 5 + 8 + 11);
    chkn("t5_ready_while_busy", viol, 0);

    // 6: async reset while in IC_WAIT
    nxt();
    empty = 1; ibusy = 1; req = 1; ftype = 1; #1;
    nxt(); req = 0; ack = 1;
    nxt(); ack = 0;
    nxt(); nxt(); nxt(); #1;
    chk1("t6_busy_in_icwait", busy, 1'b1);
    #1; rst_ni = 1'b0; #1;
    chk1("t6_async_busy", busy, 1'b0);
    chk1("t6_async_ready", ready, 1'b1);
    chk1("t6_async_done", done, 1'b0);
    chk1("t6_async_iflush", iflush, 1'b0);
    ibusy = 0;
    @(negedge clk); @(negedge clk); rst_ni = 1'b1;
    nxt(); #1;
    chk1("t6_ready_after_release", ready, 1'b1);
    chk1("t6_busy_after_release", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
